// File: rtl/magnitude_compare_unit_if.sv
// Operand/result bundle for the magnitude compare unit.
// Carries the parallel operands, cascade inputs, serial bits and all flag outputs.
interface magnitude_compare_unit_if #(
    parameter int BIT_LEN = 4
);
    logic [BIT_LEN-1:0] par_a;
    logic [BIT_LEN-1:0] par_b;
    logic               lgn_in;
    logic               e_in;
    logic               par_lgn_out;
    logic               par_e_out;
    logic               ser_a;
    logic               ser_b;
    logic               ser_lgn_out;
    logic               ser_e_out;

    modport master (
        output par_a,
        output par_b,
        output lgn_in,
        output e_in,
        output ser_a,
        output ser_b,
        input  par_lgn_out,
        input  par_e_out,
        input  ser_lgn_out,
        input  ser_e_out
    );

    modport slave (
        input  par_a,
        input  par_b,
        input  lgn_in,
        input  e_in,
        input  ser_a,
        input  ser_b,
        output par_lgn_out,
        output par_e_out,
        output ser_lgn_out,
        output ser_e_out
    );
endinterface

// File: rtl/magnitude_compare_unit.sv
// Unsigned magnitude comparator: combinational cascadable BIT_LEN-wide path
// plus a registered bit-serial path.
// Ports: clk, reset (sync, active-high, serial path only),
//        bus (slave): par_a/par_b/lgn_in/e_in -> par_lgn_out/par_e_out,
//                     ser_a/ser_b -> ser_lgn_out/ser_e_out (registered).
// Build option: COMP_SERIAL_MSB_FIRST_EN selects MSB-first serial order
// (first differing bit locks the result); default is LSB-first.
module magnitude_compare_unit #(
    parameter int BIT_LEN = 4
) (
    input logic                          clk,
    input logic                          reset,
    magnitude_compare_unit_if.slave      bus
);

    logic [BIT_LEN-1:0] w_a;
    logic [BIT_LEN-1:0] w_b;
    logic               w_lgn;
    logic               w_e;
    logic               w_ser_diff;
    logic               r_ser_lgn;
    logic               r_ser_e;

    assign w_a = bus.par_a;
    assign w_b = bus.par_b;

    // Ripple from LSB to MSB: a differing bit overrides everything below it,
    // so the most significant differing bit decides. Equal words leave the
    // cascade inputs untouched, including the illegal (1,1) pair.
    always_comb begin
        w_lgn = bus.lgn_in;
        w_e   = bus.e_in;
        for (int i = 0; i < BIT_LEN; i++) begin
            if (w_a[i] != w_b[i]) begin
                w_lgn = w_a[i];
                w_e   = 1'b0;
            end
        end
    end

    assign bus.par_lgn_out = w_lgn;
    assign bus.par_e_out   = w_e;

    assign w_ser_diff = bus.ser_a ^ bus.ser_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ser_lgn <= 1'b0;
            r_ser_e   <= 1'b1;
        end else begin
`ifdef COMP_SERIAL_MSB_FIRST_EN
            // Only the first difference counts; later bits are less significant.
            if (r_ser_e && w_ser_diff) begin
                r_ser_lgn <= bus.ser_a;
                r_ser_e   <= 1'b0;
            end
`else
            // Each new bit outranks all history, so any difference overrides.
            if (w_ser_diff) begin
                r_ser_lgn <= bus.ser_a;
                r_ser_e   <= 1'b0;
            end
`endif
        end
    end

    assign bus.ser_lgn_out = r_ser_lgn;
    assign bus.ser_e_out   = r_ser_e;

endmodule

// File: tb/tb_magnitude_compare_unit.sv
// Directed self-checking bench for magnitude_compare_unit.
// Covers parallel compare/cascade and serial reset, streaming and mid-stream reset.
module tb_magnitude_compare_unit;

    localparam int BL = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    magnitude_compare_unit_if #(.BIT_LEN(BL)) bus ();

    magnitude_compare_unit #(.BIT_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic par_vec(input string nm, input logic [BL-1:0] a,
                           input logic [BL-1:0] b, input logic li,
                           input logic ei, input logic xl, input logic xe);
        bus.par_a  = a;
        bus.par_b  = b;
        bus.lgn_in = li;
        bus.e_in   = ei;
        #1;
        total++;
        if ({bus.par_lgn_out, bus.par_e_out} !== {xl, xe}) begin
            bad++;
            $display("FAIL %s: got lgn=%b e=%b want lgn=%b e=%b",
                     nm, bus.par_lgn_out, bus.par_e_out, xl, xe);
        end
    endtask

    task automatic ser_step(input string nm, input logic rs, input logic a,
                            input logic b, input logic xl, input logic xe);
        @(negedge clk);
        reset     = rs;
        bus.ser_a = a;
        bus.ser_b = b;
        @(posedge clk);
        #1;
        total++;
        if ({bus.ser_lgn_out, bus.ser_e_out} !== {xl, xe}) begin
            bad++;
            $display("FAIL %s: got lgn=%b e=%b want lgn=%b e=%b",
                     nm, bus.ser_lgn_out, bus.ser_e_out, xl, xe);
        end
    endtask

    task automatic test_reset();
        ser_step("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ser_step("reset_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_parallel();
        par_vec("par_9_3", 4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        par_vec("par_3_9", 4'd3, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        par_vec("par_8_7", 4'd8, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        par_vec("par_7_8", 4'd7, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        par_vec("par_15_14", 4'd15, 4'd14, 1'b0, 1'b1, 1'b1, 1'b0);
        par_vec("par_14_15", 4'd14, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        par_vec("par_0_0", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        par_vec("par_15_15", 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1);
        par_vec("par_gt_casc_ign", 4'd9, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        par_vec("par_lt_casc_ign", 4'd3, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        par_vec("par_lt_casc_gt", 4'd2, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cascade();
        par_vec("casc_01", 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        par_vec("casc_10", 4'd7, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        par_vec("casc_00", 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        par_vec("casc_11", 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        par_vec("casc_10_zero", 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_par_sweep();
        logic xl;
        logic xe;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                xl = (a > b);
                xe = (a == b);
                par_vec("par_sweep", BL'(a), BL'(b), 1'b0, 1'b1, xl, xe);
            end
        end
    endtask

    task automatic test_serial_equal();
        ser_step("ser_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ser_step("ser_eq11", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        ser_step("ser_eq00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_serial_order();
        ser_step("ord_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ser_step("ord_b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef COMP_SERIAL_MSB_FIRST_EN
        ser_step("ord_b2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        ser_step("ord_b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`else
        ser_step("ord_b2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ser_step("ord_b3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    endtask

    // a=0110, b=0101 streamed LSB index first
    task automatic test_serial_stream();
        ser_step("strm_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ser_step("strm_0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef COMP_SERIAL_MSB_FIRST_EN
        ser_step("strm_1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        ser_step("strm_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        ser_step("strm_2", 1'b0, 1'b1, 1'b1, bus.ser_lgn_out === 1'b1 ?
`ifdef COMP_SERIAL_MSB_FIRST_EN
                 1'b0 : 1'b0, 1'b0);
`else
                 1'b1 : 1'b1, 1'b0);
`endif
    endtask

    task automatic test_reset_midstream();
        ser_step("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ser_step("mid_b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ser_step("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        ser_step("mid_new", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ser_step("mid_reset2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        ser_step("mid_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.par_a  = '0;
        bus.par_b  = '0;
        bus.lgn_in = 1'b0;
        bus.e_in   = 1'b1;
        bus.ser_a  = 1'b0;
        bus.ser_b  = 1'b0;
        test_reset();
        test_parallel();
        test_cascade();
        test_par_sweep();
        test_serial_equal();
        test_serial_order();
        test_serial_stream();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
